wshb_pattern_writer: RTL and testbench
======================================

// Module: wshb_pattern_writer
// PURPOSE
//  Wishbone master that fills the SDRAM framebuffer with a test pattern (RGB565, 16 bpp).
//  Sits upstream of the VGA display block: it writes the frame that the display reads back.
//  Address map: byte address 2*(HDISP*y + x), pixels written in raster order.
//  Bus is released periodically so an arbiter can serve the display reader.
// PARAMETERS
//  HDISP        640  pixels per line; must be a multiple of 8
//  VDISP        480  lines per frame
//  BURST_LEN    64   writes per bus tenure before cyc is released (>=1)
//  PAUSE_LEN    16   cycles with cyc=0 between tenures (>=1)
// PORTS
//  CLK          in   1   system clock; the Wishbone clock of the SDRAM controller
//  RST          in   1   synchronous reset, active high
//  enable       in   1   1 = keep writing frames, 0 = stop at next transfer boundary
//  pattern_sel  in   2   0 colour bars, 1 checkerboard 16x16, 2 grey ramp, 3 solid blue
//  frame_done   out  1   one-cycle pulse after the last pixel of a frame is acked
//  wshb_adr     out  32  byte address
//  wshb_dat_ms  out  16  pixel data, RGB565
//  wshb_sel     out  2   constant 2'b11
//  wshb_we      out  1   constant 1 (write only)
//  wshb_cti     out  3   constant 0 (classic cycle)
//  wshb_bte     out  2   constant 0
//  wshb_cyc     out  1   bus cycle
//  wshb_stb     out  1   strobe
//  wshb_ack     in   1   slave acknowledge
// BEHAVIOUR
//  Reset: state IDLE; x=y=0; burst_cnt=0; pause_cnt=0; cyc=stb=0; frame_done=0; adr=0; dat=0.
//  FSM IDLE: cyc=stb=0. enable=1 -> WRITE next cycle.
//  FSM WRITE: cyc=stb=1. adr/dat are registered and held stable while stb=1 and ack=0.
//   On ack: advance x (wrap at HDISP-1 to 0, then y++; y wraps at VDISP-1 to 0); burst_cnt++.
//   On ack with burst_cnt==BURST_LEN-1: burst_cnt<=0, go to PAUSE (cyc=stb=0 next cycle).
//   On ack with enable=0: go to IDLE; x/y are kept, so the next enable resumes at the next pixel.
//   Without ack, enable is ignored; a transfer is never abandoned.
//   Last-pixel ack (x=HDISP-1, y=VDISP-1): frame_done=1 on the following cycle only; next adr=0.
//   If last pixel and burst end coincide, both take effect: PAUSE entry and a frame_done pulse.
//  FSM PAUSE: cyc=stb=0 for exactly PAUSE_LEN cycles, then WRITE if enable=1, else IDLE.
//  Next adr/dat are computed from the post-ack x/y, so ack may be high every cycle with no bubble.
//  pattern_sel is latched at the first write of each frame (x=y=0); a change mid-frame has no effect
//   until the next frame.
//  Patterns, using px=x and py=y:
//   0: 8 vertical bars of HDISP/8 px: FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000. Bar index comes from a
//      bar counter, not a divider.
//   1: (px[4]^py[4]) ? FFFF : 0000
//   2: g=px*32/HDISP (5 bits); dat={g, g, 1'b0, g}
//   3: 001F
//  Address arithmetic: 32-bit unsigned, 2*(HDISP*y+x); no overflow for legal parameters.
//  RST during WRITE: cyc/stb drop in the cycle after the reset edge; the in-flight transfer is dropped.
// CONFIGURATION
//  PATTERN_SCROLL_EN defined: an offset register (reset 0) increments modulo HDISP on each frame_done.
//   Pattern x is px=(x+offset) wrapped to HDISP, so patterns 0 to 2 scroll left by 1 px per frame.
//   adr is unaffected.
//  PATTERN_SCROLL_EN undefined: offset is absent and px=x; no extra logic.
// TESTING
//  1 BURST_LEN=4, PAUSE_LEN=2, ack always 1, enable=1 -> adr 0,2,4,6; cyc=0 for 2 cycles; then adr 8.
//  2 sel=0, default params -> dat FFFF at x=0, FFE0 at x=80, 0000 at x=639; sel=1 -> (0,0)=0000,
//    (16,0)=FFFF, (16,16)=0000.
//  3 ack low 5 cycles mid-burst -> adr/dat/stb unchanged for those 5 cycles; advance on the ack cycle.
//  4 full frame with ack=1 -> last adr 614398, frame_done high exactly 1 cycle, next frame adr 0;
//    sel changed mid-frame applies only on the next frame.
//  5 enable=0 while stb waits for ack -> stays in WRITE until ack, then IDLE; re-enable resumes at
//    the next address.
//  6 RST pulse in WRITE -> cyc=stb=0 next cycle; after release, writes restart at adr 0.
//    With PATTERN_SCROLL_EN: 2nd frame x=0 gives the x=1 colour.

Source files
------------

// File: rtl/wshb_pattern_writer.sv
// wshb_pattern_writer: Wishbone write-only master that fills an RGB565 framebuffer with a test pattern.
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   enable             keep writing frames; 0 stops at the next transfer boundary
//   pattern_sel        0 colour bars, 1 checkerboard 16x16, 2 grey ramp, 3 solid blue
//   frame_done         one-cycle pulse after the last pixel of a frame is acked
//   wshb_*             Wishbone master (classic cycles, 16-bit writes, byte addresses)
// Optional feature: define PATTERN_SCROLL_EN to scroll patterns left by one pixel per frame.
module wshb_pattern_writer #(
    parameter int HDISP     = 640,
    parameter int VDISP     = 480,
    parameter int BURST_LEN = 64,
    parameter int PAUSE_LEN = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        frame_done,
    output logic [31:0] wshb_adr,
    output logic [15:0] wshb_dat_ms,
    output logic [1:0]  wshb_sel,
    output logic        wshb_we,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    input  logic        wshb_ack
);
    localparam int XW   = $clog2(HDISP);
    localparam int YW   = $clog2(VDISP);
    localparam int BW   = $clog2(BURST_LEN + 1);
    localparam int PW   = $clog2(PAUSE_LEN + 1);
    localparam int BARW = HDISP / 8;
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    typedef enum logic [1:0] {IDLE, WRITE, PAUSE} state_t;

    state_t         state;
    logic [XW-1:0]  x, px, bpos, tx, tpx, tbpos, ls_px, ls_bpos;
    logic [YW-1:0]  y, ty;
    logic [2:0]     bar, tbar, ls_bar;
    logic [BW-1:0]  burst_cnt;
    logic [PW-1:0]  pause_cnt;
    logic [1:0]     sel_q, eff_sel;
    logic [4:0]     g;
    logic [15:0]    n_dat;
    logic           adv, x_end, y_end, last, bpos_end, chk;

    assign wshb_sel = 2'b11;
    assign wshb_we  = 1'b1;
    assign wshb_cti = 3'b000;
    assign wshb_bte = 2'b00;

`ifdef PATTERN_SCROLL_EN
    // Pattern-space start of each line; advances by one pixel per frame.
    logic [XW-1:0] ofs, ofs_bpos;
    logic [2:0]    ofs_bar;
    always_comb begin
        ls_px   = ofs;
        ls_bpos = ofs_bpos;
        ls_bar  = ofs_bar;
        if (last) begin
            ls_px   = (ofs == XW'(HDISP - 1)) ? '0 : ofs + XW'(1);
            ls_bpos = (ofs_bpos == XW'(BARW - 1)) ? '0 : ofs_bpos + XW'(1);
            ls_bar  = ofs_bar + 3'(ofs_bpos == XW'(BARW - 1));
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            ofs      <= '0;
            ofs_bpos <= '0;
            ofs_bar  <= '0;
        end else if (adv && last) begin
            ofs      <= ls_px;
            ofs_bpos <= ls_bpos;
            ofs_bar  <= ls_bar;
        end
    end
`else
    always_comb begin
        ls_px   = '0;
        ls_bpos = '0;
        ls_bar  = '0;
    end
`endif

    // t* is the pixel that adr/dat must present next: the following pixel on an ack, else the current one.
    // Bar index and position within the bar are tracked incrementally alongside px.
    always_comb begin
        adv      = state == WRITE && wshb_ack;
        x_end    = x == XW'(HDISP - 1);
        y_end    = y == YW'(VDISP - 1);
        last     = x_end && y_end;
        bpos_end = bpos == XW'(BARW - 1);
        tx       = adv ? (x_end ? '0 : x + XW'(1)) : x;
        ty       = (adv && x_end) ? (y_end ? '0 : y + YW'(1)) : y;
        tpx      = !adv ? px : x_end ? ls_px : (px == XW'(HDISP - 1)) ? '0 : px + XW'(1);
        tbpos    = !adv ? bpos : x_end ? ls_bpos : bpos_end ? '0 : bpos + XW'(1);
        tbar     = !adv ? bar : x_end ? ls_bar : bar + 3'(bpos_end);
        eff_sel  = (tx == '0 && ty == '0) ? pattern_sel : sel_q;
        g        = 5'(32'(tpx) * 32 / HDISP);
        chk      = 1'(32'(tpx) >> 4) ^ 1'(32'(ty) >> 4);
        n_dat    = eff_sel == 2'd0 ? BARS[tbar] :
                   eff_sel == 2'd1 ? (chk ? 16'hFFFF : 16'h0000) :
                   eff_sel == 2'd2 ? {g, g, 1'b0, g} : 16'h001F;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            px          <= '0;
            bpos        <= '0;
            bar         <= '0;
            burst_cnt   <= '0;
            pause_cnt   <= '0;
            sel_q       <= '0;
            frame_done  <= 1'b0;
            wshb_adr    <= '0;
            wshb_dat_ms <= '0;
            wshb_cyc    <= 1'b0;
            wshb_stb    <= 1'b0;
        end else begin
            x          <= tx;
            y          <= ty;
            px         <= tpx;
            bpos       <= tbpos;
            bar        <= tbar;
            frame_done <= adv && last;
            // Hold dat (and the latched pattern) while a transfer waits for ack.
            if (!(wshb_stb && !wshb_ack)) begin
                wshb_dat_ms <= n_dat;
                sel_q       <= eff_sel;
            end
            if (adv)
                wshb_adr <= last ? '0 : wshb_adr + 32'd2;
            case (state)
                IDLE: if (enable) begin
                    state    <= WRITE;
                    wshb_cyc <= 1'b1;
                    wshb_stb <= 1'b1;
                end
                WRITE: if (wshb_ack) begin
                    if (burst_cnt == BW'(BURST_LEN - 1)) begin
                        burst_cnt <= '0;
                        pause_cnt <= '0;
                        state     <= PAUSE;
                        wshb_cyc  <= 1'b0;
                        wshb_stb  <= 1'b0;
                    end else begin
                        burst_cnt <= burst_cnt + BW'(1);
                        if (!enable) begin
                            state    <= IDLE;
                            wshb_cyc <= 1'b0;
                            wshb_stb <= 1'b0;
                        end
                    end
                end
                PAUSE: if (pause_cnt == PW'(PAUSE_LEN - 1)) begin
                    state    <= enable ? WRITE : IDLE;
                    wshb_cyc <= enable;
                    wshb_stb <= enable;
                end else begin
                    pause_cnt <= pause_cnt + PW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wshb_pattern_writer.sv
// tb_wshb_pattern_writer: directed bench for wshb_pattern_writer (640x17 frame, 4-write bursts, 2-cycle pause).
module tb_wshb_pattern_writer;
    localparam int H = 640;
    localparam int V = 17;

    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, ack = 1'b0;
    logic [1:0]  psel = 2'd0;
    logic        frame_done, we, cyc, stb;
    logic [31:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel, bte;
    logic [2:0]  cti;
    int          checks = 0, errors = 0, fd_count = 0;
    logic        fd_prev = 1'b0;

    typedef struct {
        logic [1:0]  sel;
        int          x;
        int          y;
        logic [15:0] dat;
    } vec_t;
    vec_t tbl [19];

    wshb_pattern_writer #(.HDISP(H), .VDISP(V), .BURST_LEN(4), .PAUSE_LEN(2)) dut (
        .CLK(clk), .RST(rst), .enable(enable), .pattern_sel(psel), .frame_done(frame_done),
        .wshb_adr(adr), .wshb_dat_ms(dat), .wshb_sel(sel), .wshb_we(we), .wshb_cti(cti),
        .wshb_bte(bte), .wshb_cyc(cyc), .wshb_stb(stb), .wshb_ack(ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (frame_done) begin
            fd_count++;
            check("frame_done_width", 32'(fd_prev), 32'd0);
        end
        fd_prev = frame_done;
    endtask

    task automatic wait_adr(input logic [31:0] a);
        int n = 0;
        while (!(cyc && adr == a) && n < 40000) begin
            tick();
            n++;
        end
        if (!(cyc && adr == a)) begin
            checks++;
            errors++;
            $display("FAIL wait_adr: timeout, adr %0h required %0h", adr, a);
        end
    endtask

    initial begin
        logic [31:0] exp_adr [7];
        logic        exp_cyc [7];
        tbl = '{
            '{2'd1, 80, 0, 16'hFFE0}, '{2'd1, 639, 0, 16'h0000}, '{2'd1, 160, 1, 16'h07FF},
            '{2'd1, 320, 5, 16'hF81F}, '{2'd1, 400, 9, 16'hF800}, '{2'd1, 240, 16, 16'h07E0},
            '{2'd1, 480, 16, 16'h001F}, '{2'd1, 639, 16, 16'h0000},
            '{2'd1, 0, 0, 16'h0000}, '{2'd1, 16, 0, 16'hFFFF}, '{2'd1, 32, 3, 16'h0000},
            '{2'd1, 31, 15, 16'hFFFF}, '{2'd1, 0, 16, 16'hFFFF}, '{2'd1, 16, 16, 16'h0000},
            '{2'd2, 48, 16, 16'h0000},
            '{2'd2, 0, 0, 16'h0000}, '{2'd2, 20, 0, 16'h0841}, '{2'd2, 320, 0, 16'h8410},
            '{2'd2, 639, 0, 16'hFFDF}
        };
        exp_cyc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_adr = '{32'd0, 32'd2, 32'd4, 32'd6, 32'd0, 32'd0, 32'd8};

        repeat (3) tick();
        check("rst_cyc", 32'(cyc), 32'd0);
        check("rst_stb", 32'(stb), 32'd0);
        check("rst_adr", adr, 32'd0);
        check("rst_dat", 32'(dat), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("const_sel", 32'(sel), 32'd3);
        check("const_we", 32'(we), 32'd1);
        check("const_cti", 32'(cti), 32'd0);
        check("const_bte", 32'(bte), 32'd0);

        rst = 1'b0;
        enable = 1'b1;
        ack = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("burst_cyc[%0d]", i), 32'(cyc), 32'(exp_cyc[i]));
            check($sformatf("burst_stb[%0d]", i), 32'(stb), 32'(exp_cyc[i]));
            if (exp_cyc[i]) check($sformatf("burst_adr[%0d]", i), adr, exp_adr[i]);
            if (i == 0) check("first_dat", 32'(dat), 32'hFFFF);
        end

        for (int i = 0; i < 19; i++) begin
            psel = tbl[i].sel;
            wait_adr(32'(2 * (H * tbl[i].y + tbl[i].x)));
            check($sformatf("dat[%0d](%0d,%0d)", i, tbl[i].x, tbl[i].y), 32'(dat), 32'(tbl[i].dat));
            if (i == 7) begin
                tick();
                check("fd_pulse", 32'(frame_done), 32'd1);
                check("fd_pause_cyc", 32'(cyc), 32'd0);
                tick();
                check("fd_low", 32'(frame_done), 32'd0);
                check("fd_pause_cyc2", 32'(cyc), 32'd0);
                tick();
                check("new_frame_cyc", 32'(cyc), 32'd1);
                check("new_frame_adr", adr, 32'd0);
            end
        end

        wait_adr(32'd1282);
        ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall_stb[%0d]", i), 32'(stb), 32'd1);
            check($sformatf("stall_adr[%0d]", i), adr, 32'd1282);
            check($sformatf("stall_dat[%0d]", i), 32'(dat), 32'd0);
        end
        ack = 1'b1;
        tick();
        check("stall_release_adr", adr, 32'd1284);

        ack = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stop_wait_cyc[%0d]", i), 32'(cyc), 32'd1);
            check($sformatf("stop_wait_adr[%0d]", i), adr, 32'd1284);
        end
        ack = 1'b1;
        tick();
        check("stop_cyc", 32'(cyc), 32'd0);
        check("stop_stb", 32'(stb), 32'd0);
        check("stop_adr", adr, 32'd1286);
        repeat (2) tick();
        check("idle_cyc", 32'(cyc), 32'd0);
        enable = 1'b1;
        tick();
        check("resume_cyc", 32'(cyc), 32'd1);
        check("resume_adr", adr, 32'd1286);

        rst = 1'b1;
        psel = 2'd3;
        tick();
        check("rst_write_cyc", 32'(cyc), 32'd0);
        check("rst_write_stb", 32'(stb), 32'd0);
        check("rst_write_adr", adr, 32'd0);
        rst = 1'b0;
        tick();
        check("restart_cyc", 32'(cyc), 32'd1);
        check("restart_adr", adr, 32'd0);
        check("restart_dat", 32'(dat), 32'h001F);
        tick();
        check("restart_adr2", adr, 32'd2);
        check("restart_dat2", 32'(dat), 32'h001F);
        check("frame_done_count", 32'(fd_count), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
